// File: rtl/spu_fw_pkg.sv
// Shared types and constants for the SPU forwarding scoreboard.
// Provides the default geometry, the register/latency field widths, the
// clog2-derived pipe/stage index widths and the per-stage tracking entry.
package spu_fw_pkg;

    localparam int DEF_NUM_PIPES   = 2;
    localparam int DEF_DEPTH       = 7;
    localparam int DEF_NUM_SRC     = 3;
    localparam int DEF_FLUSH_DEPTH = 2;

    localparam int REG_AW = 7;  // 128 architectural registers
    localparam int LAT_W  = 5;

    // Pipe index width; kept at least 1 so a single-pipe build still has a port.
    function automatic int pw_of(input int num_pipes);
        return (num_pipes > 1) ? $clog2(num_pipes) : 1;
    endfunction

    // Stage numbers run 1..depth, so the field must hold depth itself.
    function automatic int sw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PW = pw_of(DEF_NUM_PIPES);
    localparam int SW = sw_of(DEF_DEPTH);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] dst;
        logic [LAT_W-1:0]  rem;   // cycles until the result exists; 0 = bypassable
    } fw_entry_t;

endpackage

// File: rtl/spu_forward_scoreboard_if.sv
// Issue/lookup bus between decode/issue and the forwarding scoreboard.
// master: issue logic (drives issue, operand lookup and flush; receives bypass
//         selects and stall).
// slave : the scoreboard.
interface spu_forward_scoreboard_if
    import spu_fw_pkg::*;
#(
    parameter int NUM_PIPES = DEF_NUM_PIPES,
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int DEPTH     = DEF_DEPTH
) ();

    localparam int IPW = pw_of(NUM_PIPES);
    localparam int ISW = sw_of(DEPTH);

    logic [NUM_PIPES-1:0]                issue_valid;
    logic [NUM_PIPES-1:0]                issue_wr;
    logic [NUM_PIPES*REG_AW-1:0]         issue_dst;
    logic [NUM_PIPES*LAT_W-1:0]          issue_lat;
    logic [NUM_PIPES*NUM_SRC*REG_AW-1:0] src_addr;
    logic [NUM_PIPES*NUM_SRC-1:0]        src_used;
    logic                                flush;
    logic [NUM_PIPES*NUM_SRC-1:0]        fw_en;
    logic [NUM_PIPES*NUM_SRC*IPW-1:0]    fw_pipe;
    logic [NUM_PIPES*NUM_SRC*ISW-1:0]    fw_stage;
    logic                                stall;

    modport master (
        output issue_valid, issue_wr, issue_dst, issue_lat, src_addr, src_used, flush,
        input  fw_en, fw_pipe, fw_stage, stall
    );

    modport slave (
        input  issue_valid, issue_wr, issue_dst, issue_lat, src_addr, src_used, flush,
        output fw_en, fw_pipe, fw_stage, stall
    );

endinterface

// File: rtl/fw_track_pipe.sv
// Per-pipe in-flight write tracker: a DEPTH-stage shift register where every
// entry carries a latency countdown. Stage 1 (index 0) loads the issued
// instruction; each clock all entries advance one stage and count down.
// flush kills stages 1..FLUSH_DEPTH after the shift, including this cycle's issue.
// Ports: clk, reset_n (async active-low), issue_valid/wr/dst/lat, flush,
//        entries_o (stage s+1 at index s).
module fw_track_pipe
    import spu_fw_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        issue_valid,
    input  logic                        issue_wr,
    input  logic [REG_AW-1:0]           issue_dst,
    input  logic [LAT_W-1:0]            issue_lat,
    input  logic                        flush,
    output fw_entry_t [DEPTH-1:0]       entries_o
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             wr_q, wr_d;
    logic [DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
    logic [DEPTH-1:0][LAT_W-1:0]  rem_q, rem_d;
    logic [LAT_W-1:0]             lat_clamped;

    // NOTE: every always_comb output gets a value before any branch, so no latch can form.
    always_comb begin
        lat_clamped = issue_lat;
        if (issue_lat == '0) begin
            lat_clamped = LAT_W'(1);
        end else if (issue_lat > LAT_W'(DEPTH)) begin
            lat_clamped = LAT_W'(DEPTH);
        end

        valid_d[0] = issue_valid & ~flush;
        wr_d[0]    = issue_wr;
        dst_d[0]   = issue_dst;
        rem_d[0]   = lat_clamped - LAT_W'(1);

        for (int s = 1; s < DEPTH; s++) begin
            // Index s is stage s+1 after the shift; stages 1..FLUSH_DEPTH die on flush.
            valid_d[s] = valid_q[s-1] & ~(flush && (s < FLUSH_DEPTH));
            wr_d[s]    = wr_q[s-1];
            dst_d[s]   = dst_q[s-1];
            rem_d[s]   = (rem_q[s-1] == '0) ? '0 : rem_q[s-1] - LAT_W'(1);
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: payload fields are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        wr_q  <= wr_d;
        dst_q <= dst_d;
        rem_q <= rem_d;
    end

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            entries_o[s].valid = valid_q[s];
            entries_o[s].wr    = wr_q[s];
            entries_o[s].dst   = dst_q[s];
            entries_o[s].rem   = rem_q[s];
        end
    end

endmodule

// File: rtl/spu_forward_scoreboard.sv
// Forwarding scoreboard for the dual-issue SPU datapath.
// Tracks in-flight register writes per pipe and, for every operand in decode,
// picks the youngest matching producer (lowest stage, then highest pipe).
// A ready winner is bypassed; a not-ready winner raises stall.
// Ports: clk, reset_n (async active-low), bus (slave side of the issue/lookup bus).
module spu_forward_scoreboard
    import spu_fw_pkg::*;
#(
    parameter int NUM_PIPES   = DEF_NUM_PIPES,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    spu_forward_scoreboard_if.slave   bus
);

    localparam int TPW    = pw_of(NUM_PIPES);
    localparam int TSW    = sw_of(DEPTH);
    localparam int NUM_OP = NUM_PIPES * NUM_SRC;

    fw_entry_t [DEPTH-1:0] entries [NUM_PIPES];

    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        fw_track_pipe #(
            .DEPTH       (DEPTH),
            .FLUSH_DEPTH (FLUSH_DEPTH)
        ) u_track (
            .clk         (clk),
            .reset_n     (reset_n),
            .issue_valid (bus.issue_valid[p]),
            .issue_wr    (bus.issue_wr[p]),
            .issue_dst   (bus.issue_dst[p*REG_AW +: REG_AW]),
            .issue_lat   (bus.issue_lat[p*LAT_W +: LAT_W]),
            .flush       (bus.flush),
            .entries_o   (entries[p])
        );
    end

    logic [NUM_OP-1:0]     fw_en_c;
    logic [NUM_OP*TPW-1:0] fw_pipe_c;
    logic [NUM_OP*TSW-1:0] fw_stage_c;
    logic                  stall_c;

    always_comb begin
        fw_en_c    = '0;
        fw_pipe_c  = '0;
        fw_stage_c = '0;
        stall_c    = 1'b0;
        for (int i = 0; i < NUM_OP; i++) begin
            logic           found;
            logic           win_ready;
            logic [TPW-1:0] win_pipe;
            logic [TSW-1:0] win_stage;
            found     = 1'b0;
            win_ready = 1'b0;
            win_pipe  = '0;
            win_stage = '0;
            // Scan youngest first; the first hit is the only one that counts,
            // so an older ready copy never hides a younger pending write.
            for (int s = 0; s < DEPTH; s++) begin
                for (int q = NUM_PIPES - 1; q >= 0; q--) begin
                    if (!found && bus.src_used[i] && entries[q][s].valid && entries[q][s].wr &&
                        (entries[q][s].dst == bus.src_addr[i*REG_AW +: REG_AW])) begin
                        found     = 1'b1;
                        win_ready = (entries[q][s].rem == '0);
                        win_pipe  = TPW'(q);
                        win_stage = TSW'(s + 1);
                    end
                end
            end
            if (found && win_ready) begin
                fw_en_c[i]                = 1'b1;
                fw_pipe_c[i*TPW +: TPW]   = win_pipe;
                fw_stage_c[i*TSW +: TSW]  = win_stage;
            end
            if (found && !win_ready) begin
                stall_c = 1'b1;
            end
        end
    end

    assign bus.fw_en    = fw_en_c;
    assign bus.fw_pipe  = fw_pipe_c;
    assign bus.fw_stage = fw_stage_c;
    assign bus.stall    = stall_c;

endmodule
